// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state, mode and lane-framing definitions for the serial system bus
package bus_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEL_RX    = 3'd1;
    localparam logic [2:0] ST_SEL_CHECK = 3'd2;
    localparam logic [2:0] ST_SELECTED  = 3'd3;
    localparam logic [2:0] ST_HDR_RX    = 3'd4;
    localparam logic [2:0] ST_DATA_RX   = 3'd5;

    typedef enum logic {
        MODE_WRITE = 1'b0,
        MODE_READ  = 1'b1
    } mode_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam int   BURST_OFS = 1;

endpackage

// File: rtl/serial_shift_rx.sv
// rtl/serial_shift_rx.sv - LSB-first serial bit collector with enable, clear and done
module serial_shift_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] word_next,
    output logic             last,
    output logic             done
);
    localparam int IW = $clog2(WIDTH + 1);

    logic [IW-1:0] idx;

    assign last = (idx == IW'(WIDTH - 1));
    assign done = en & last;

    // word_next includes the bit arriving this cycle so callers can act on a completed word without a cycle of lag
    always_comb begin
        word_next = word;
        for (int i = 0; i < WIDTH; i++) begin
            if (en && idx == IW'(i)) begin
                word_next[i] = bit_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (en) begin
            word <= word_next;
            idx  <= last ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/slave_in.sv
// rtl/slave_in.sv - slave-side serial bus receiver issuing memory writes and read requests
module slave_in
    import bus_pkg::*;
#(
    parameter int                   SLAVE_LEN = 2,
    parameter int                   ADDR_LEN  = 12,
    parameter int                   DATA_LEN  = 8,
    parameter int                   BURST_LEN = 12,
    parameter logic [SLAVE_LEN-1:0] SLAVE_ID  = '0,
    parameter int                   TIMEOUT   = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                approval_grant,
    input  logic                rx_slave_select,
    input  logic                rx_address,
    input  logic                rx_burst_number,
    input  logic                rx_data,
    input  logic                master_valid,
    input  logic                write_en,
    input  logic                read_en,
    output logic                slave_ready,
    output logic                mem_wr_en,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                rd_req,
    output logic [ADDR_LEN-1:0] rd_addr,
    output logic                rx_done
);
    localparam int SEL_W = $clog2(SLAVE_LEN + 1);
    localparam int HC_W  = $clog2(BURST_LEN + 2);
    localparam int WT_W  = $clog2(TIMEOUT + 1);
    localparam logic [BURST_LEN:0] BEATS_ONE = {{BURST_LEN{1'b0}}, 1'b1};

    logic [2:0]           state;
    mode_t                mode;
    logic [SEL_W-1:0]     sel_cnt;
    logic [SLAVE_LEN-1:0] sel_sr;
    logic [WT_W-1:0]      wait_cnt;
    logic [HC_W-1:0]      hdr_cnt;
    logic [BURST_LEN:0]   beats_left;
    logic [ADDR_LEN-1:0]  beat_idx;

    logic                 lanes_clear, addr_en, burst_en, data_en;
    logic [ADDR_LEN-1:0]  addr_q, addr_next;
    logic [BURST_LEN-1:0] burst_q, burst_next;
    logic [DATA_LEN-1:0]  word_q, word_next;
    logic                 data_last, beat_done;
    logic                 unused_lane_flags;
    logic                 addr_last, addr_done, burst_last, burst_done;

    assign lanes_clear = (state == ST_IDLE);
    assign addr_en     = (state == ST_HDR_RX) && (hdr_cnt < HC_W'(ADDR_LEN));
    assign burst_en    = (state == ST_HDR_RX) && (hdr_cnt >= HC_W'(BURST_OFS));
    // During the header a finished word has nowhere to go yet, so collection stalls on its last bit
    assign data_en     = master_valid &&
                         ((state == ST_DATA_RX) || ((state == ST_HDR_RX) && !data_last));
    assign unused_lane_flags = &{1'b0, addr_last, addr_done, burst_last, burst_done, word_q, burst_q};

    serial_shift_rx #(.WIDTH(ADDR_LEN)) u_addr_rx (
        .clk(clk), .reset_n(reset_n), .clear(lanes_clear), .en(addr_en), .bit_in(rx_address),
        .word(addr_q), .word_next(addr_next), .last(addr_last), .done(addr_done)
    );

    serial_shift_rx #(.WIDTH(BURST_LEN)) u_burst_rx (
        .clk(clk), .reset_n(reset_n), .clear(lanes_clear), .en(burst_en), .bit_in(rx_burst_number),
        .word(burst_q), .word_next(burst_next), .last(burst_last), .done(burst_done)
    );

    serial_shift_rx #(.WIDTH(DATA_LEN)) u_data_rx (
        .clk(clk), .reset_n(reset_n), .clear(lanes_clear), .en(data_en), .bit_in(rx_data),
        .word(word_q), .word_next(word_next), .last(data_last), .done(beat_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            mode        <= MODE_WRITE;
            sel_cnt     <= '0;
            sel_sr      <= '0;
            wait_cnt    <= '0;
            hdr_cnt     <= '0;
            beats_left  <= '0;
            beat_idx    <= '0;
            slave_ready <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            rx_done     <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            rd_req    <= 1'b0;
            rx_done   <= 1'b0;
            if (state != ST_IDLE && !approval_grant) begin
                state       <= ST_IDLE;
                slave_ready <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (approval_grant && rx_slave_select == START_BIT) begin
                            state   <= ST_SEL_RX;
                            sel_cnt <= '0;
                        end
                    end
                    ST_SEL_RX: begin
                        for (int i = 0; i < SLAVE_LEN; i++) begin
                            if (sel_cnt == SEL_W'(i)) sel_sr[i] <= rx_slave_select;
                        end
                        sel_cnt <= sel_cnt + SEL_W'(1);
                        if (sel_cnt == SEL_W'(SLAVE_LEN - 1)) state <= ST_SEL_CHECK;
                    end
                    ST_SEL_CHECK: begin
                        if (rx_slave_select == STOP_BIT && sel_sr == SLAVE_ID) begin
                            state       <= ST_SELECTED;
                            slave_ready <= 1'b1;
                            wait_cnt    <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_SELECTED: begin
                        if (write_en || read_en) begin
                            state   <= ST_HDR_RX;
                            mode    <= write_en ? MODE_WRITE : MODE_READ;
                            hdr_cnt <= '0;
                        end else if (wait_cnt == WT_W'(TIMEOUT - 1)) begin
                            state       <= ST_IDLE;
                            slave_ready <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + WT_W'(1);
                        end
                    end
                    ST_HDR_RX: begin
                        if (hdr_cnt == HC_W'(BURST_LEN)) begin
                            if (mode == MODE_READ) begin
                                rd_req      <= 1'b1;
                                rd_addr     <= addr_next;
                                rx_done     <= 1'b1;
                                state       <= ST_IDLE;
                                slave_ready <= 1'b0;
                            end else begin
                                state      <= ST_DATA_RX;
                                beat_idx   <= '0;
                                beats_left <= (burst_next == '0) ? BEATS_ONE : {1'b0, burst_next};
                            end
                        end else begin
                            hdr_cnt <= hdr_cnt + HC_W'(1);
                        end
                    end
                    ST_DATA_RX: begin
                        if (beat_done) begin
                            mem_wr_en  <= 1'b1;
                            mem_wdata  <= word_next;
                            mem_addr   <= addr_q + beat_idx;
                            beat_idx   <= beat_idx + ADDR_LEN'(1);
                            beats_left <= beats_left - BEATS_ONE;
                            if (beats_left == BEATS_ONE) begin
                                rx_done     <= 1'b1;
                                state       <= ST_IDLE;
                                slave_ready <= 1'b0;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slave_in.sv
// tb/tb_slave_in.sv - directed self-checking bench for slave_in
module tb_slave_in;
    localparam int ADDR_LEN  = 12;
    localparam int DATA_LEN  = 8;
    localparam int BURST_LEN = 12;

    logic clk = 1'b0;
    logic reset_n, approval_grant, rx_slave_select, rx_address, rx_burst_number;
    logic rx_data, master_valid, write_en, read_en;
    logic slave_ready, mem_wr_en, rd_req, rx_done;
    logic [ADDR_LEN-1:0] mem_addr, rd_addr;
    logic [DATA_LEN-1:0] mem_wdata;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int rd_count = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    slave_in #(
        .SLAVE_LEN(2), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN),
        .BURST_LEN(BURST_LEN), .SLAVE_ID(2'd1), .TIMEOUT(12)
    ) dut (
        .clk(clk), .reset_n(reset_n), .approval_grant(approval_grant),
        .rx_slave_select(rx_slave_select), .rx_address(rx_address),
        .rx_burst_number(rx_burst_number), .rx_data(rx_data),
        .master_valid(master_valid), .write_en(write_en), .read_en(read_en),
        .slave_ready(slave_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .rd_req(rd_req), .rd_addr(rd_addr), .rx_done(rx_done)
    );

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_wr_en) wr_count++;
            if (rd_req) rd_count++;
            if (rx_done) done_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_select(input logic [1:0] sel, input logic stop);
        rx_slave_select = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            rx_slave_select = sel[i];
            tick();
        end
        rx_slave_select = stop;
        tick();
        rx_slave_select = 1'b0;
    endtask

    task automatic send_hdr(input logic we, input logic re, input logic [11:0] addr, input logic [11:0] burst);
        write_en = we;
        read_en  = re;
        tick();
        write_en = 1'b0;
        read_en  = 1'b0;
        for (int c = 0; c <= BURST_LEN; c++) begin
            rx_address      = (c < ADDR_LEN) ? addr[c] : 1'b0;
            rx_burst_number = (c == 0) ? 1'b0 : burst[c-1];
            tick();
        end
        rx_address      = 1'b0;
        rx_burst_number = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            master_valid = 1'b1;
            rx_data      = d[i];
            tick();
        end
        master_valid = 1'b0;
        rx_data      = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; approval_grant = 1'b1; rx_slave_select = 1'b0;
        rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0;
        master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
        tick(); tick();
        check("reset_slave_ready", slave_ready, 0);
        check("reset_strobes", {mem_wr_en, rd_req, rx_done}, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_rd_addr", rd_addr, 0);
        reset_n = 1'b1;
        tick();

        // single-beat write
        send_select(2'b01, 1'b0);
        check("t1_selected", slave_ready, 1);
        send_hdr(1'b1, 1'b0, 12'h0A5, 12'd0);
        send_bits(8'h3C, 8);
        check("t1_wr_en", mem_wr_en, 1);
        check("t1_addr", mem_addr, 12'h0A5);
        check("t1_data", mem_wdata, 8'h3C);
        check("t1_done", rx_done, 1);
        tick();
        check("t1_wr_pulse", mem_wr_en, 0);
        check("t1_ready_off", slave_ready, 0);
        check("t1_wr_count", wr_count, 1);

        // wrong id, then bad stop bit
        send_select(2'b10, 1'b0);
        check("t2_wrong_id", slave_ready, 0);
        tick();
        check("t2_wrong_id_hold", slave_ready, 0);
        send_select(2'b01, 1'b1);
        check("t2_bad_stop", slave_ready, 0);
        tick();
        check("t2_bad_stop_hold", slave_ready, 0);
        check("t2_no_strobes", wr_count + rd_count, 1);

        // burst of 3 wrapping at the top of the address space
        send_select(2'b01, 1'b0);
        send_hdr(1'b1, 1'b0, 12'hFFF, 12'd3);
        send_bits(8'h11, 8);
        check("t3_b0_addr", mem_addr, 12'hFFF);
        check("t3_b0_data", mem_wdata, 8'h11);
        check("t3_b0_nodone", rx_done, 0);
        send_bits(8'h22, 8);
        check("t3_b1_addr", mem_addr, 12'h000);
        check("t3_b1_data", mem_wdata, 8'h22);
        check("t3_b1_nodone", rx_done, 0);
        send_bits(8'h33, 8);
        check("t3_b2_addr", mem_addr, 12'h001);
        check("t3_b2_data", mem_wdata, 8'h33);
        check("t3_b2_done", {mem_wr_en, rx_done}, 2'b11);
        tick();
        check("t3_wr_count", wr_count, 4);
        check("t3_ready_off", slave_ready, 0);

        // read request
        send_select(2'b01, 1'b0);
        send_hdr(1'b0, 1'b1, 12'h123, 12'd5);
        check("t4_rd_req", rd_req, 1);
        check("t4_rd_done", rx_done, 1);
        check("t4_rd_addr", rd_addr, 12'h123);
        check("t4_no_wr", mem_wr_en, 0);
        tick();
        check("t4_rd_pulse", rd_req, 0);
        check("t4_rd_count", rd_count, 1);
        check("t4_rd_addr_hold", rd_addr, 12'h123);

        // selection timeout, then command accepted on the last waiting cycle
        send_select(2'b01, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        check("t5_still_ready", slave_ready, 1);
        tick();
        check("t5_timeout", slave_ready, 0);
        send_select(2'b01, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        send_hdr(1'b1, 1'b0, 12'h010, 12'd0);
        check("t5_late_cmd_ready", slave_ready, 1);
        send_bits(8'h5A, 8);
        check("t5_late_wr", {mem_wr_en, rx_done}, 2'b11);
        check("t5_late_addr", mem_addr, 12'h010);
        check("t5_late_data", mem_wdata, 8'h5A);
        tick();

        // grant dropped during the second beat of a 4-beat burst
        send_select(2'b01, 1'b0);
        send_hdr(1'b1, 1'b0, 12'h200, 12'd4);
        send_bits(8'hAA, 8);
        check("t6_b0_addr", mem_addr, 12'h200);
        check("t6_b0_data", mem_wdata, 8'hAA);
        send_bits(8'hBB, 3);
        approval_grant = 1'b0;
        tick();
        check("t6_abort_ready", slave_ready, 0);
        approval_grant = 1'b1;
        send_bits(8'hBB, 8);
        tick();
        check("t6_abort_wr_count", wr_count, 6);
        check("t6_abort_done_count", done_count, 4);

        // asynchronous reset mid-transfer
        send_select(2'b01, 1'b0);
        send_hdr(1'b1, 1'b0, 12'h0F0, 12'd2);
        send_bits(8'h77, 4);
        check("t7_pre_ready", slave_ready, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_async_ready", slave_ready, 0);
        check("t7_async_mem_addr", mem_addr, 0);
        check("t7_async_wdata", mem_wdata, 0);
        check("t7_async_rd_addr", rd_addr, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t7_after_reset", {slave_ready, mem_wr_en}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
